// File: rtl/ctrl_seq_unit.sv
// rtl/ctrl_seq_unit.sv - registered RV32 control decoder with M-unit latency sequencing (option: CTRL_DIV_EN)
module ctrl_seq_unit #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inst_valid,
    output logic       inst_ready,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_0,
    input  logic       flush,
    output logic       ctrl_valid,
    output logic       branch,
    output logic       mem_read,
    output logic       mem_write,
    output logic       alu_src,
    output logic       reg_write,
    output logic       jal,
    output logic       jalr,
    output logic       auipc,
    output logic [1:0] alu_op,
    output logic [1:0] wb_src,
    output logic       md_start,
    output logic       md_div,
    output logic       busy,
    output logic       illegal
);

    typedef enum logic {S_IDLE, S_MD} state_t;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Counter reload values: the op completes when the counter reaches zero.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             branch_q, branch_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             alu_src_q, alu_src_d;
    logic             reg_write_q, reg_write_d;
    logic             jal_q, jal_d;
    logic             jalr_q, jalr_d;
    logic             auipc_q, auipc_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic [1:0]       wb_src_q, wb_src_d;
    logic             md_start_q, md_start_d;
    logic             md_div_q, md_div_d;
    logic             illegal_q, illegal_d;
    logic             md_done;
    logic             unused_funct3;

    // Only funct3[2] distinguishes the MUL and DIV groups; the rest belongs to the ALU.
    assign unused_funct3 = ^funct3[1:0];

    // Flush beats a completion landing in the same cycle, so completion is gated live.
    assign md_done = (state_q == S_MD) && (cnt_q == '0) && !flush;

    // Decode accepted instructions and advance the M-unit latency counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = 1'b0;
        branch_d    = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        alu_src_d   = 1'b0;
        reg_write_d = 1'b0;
        jal_d       = 1'b0;
        jalr_d      = 1'b0;
        auipc_d     = 1'b0;
        alu_op_d    = 2'b00;
        wb_src_d    = 2'b00;
        md_start_d  = 1'b0;
        md_div_d    = 1'b0;
        illegal_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (inst_valid && !flush) begin
                    case (opcode)
                        OP_OP: begin
                            if (!funct7_0) begin
                                valid_d     = 1'b1;
                                reg_write_d = 1'b1;
                                alu_op_d    = 2'b10;
                            end else if (!funct3[2]) begin
                                md_start_d = 1'b1;
                            end else begin
`ifdef CTRL_DIV_EN
                                md_start_d = 1'b1;
                                md_div_d   = 1'b1;
`else
                                illegal_d  = 1'b1;
`endif
                            end
                        end
                        OP_IMM: begin
                            valid_d     = 1'b1;
                            reg_write_d = 1'b1;
                            alu_src_d   = 1'b1;
                            alu_op_d    = 2'b10;
                        end
                        OP_LOAD: begin
                            valid_d     = 1'b1;
                            reg_write_d = 1'b1;
                            alu_src_d   = 1'b1;
                            mem_read_d  = 1'b1;
                            wb_src_d    = 2'b01;
                        end
                        OP_STORE: begin
                            valid_d     = 1'b1;
                            alu_src_d   = 1'b1;
                            mem_write_d = 1'b1;
                        end
                        OP_BRANCH: begin
                            valid_d  = 1'b1;
                            branch_d = 1'b1;
                            alu_op_d = 2'b01;
                        end
                        OP_JAL: begin
                            valid_d     = 1'b1;
                            jal_d       = 1'b1;
                            reg_write_d = 1'b1;
                            wb_src_d    = 2'b10;
                        end
                        OP_JALR: begin
                            valid_d     = 1'b1;
                            jalr_d      = 1'b1;
                            reg_write_d = 1'b1;
                            alu_src_d   = 1'b1;
                            wb_src_d    = 2'b10;
                        end
                        OP_AUIPC: begin
                            valid_d     = 1'b1;
                            auipc_d     = 1'b1;
                            reg_write_d = 1'b1;
                            alu_src_d   = 1'b1;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                    if (md_start_d) begin
                        state_d = S_MD;
                        cnt_d   = md_div_d ? DIV_LOAD : MUL_LOAD;
                    end
                end
            end
            S_MD: begin
                if (flush || (cnt_q == '0)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered control bundle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            branch_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            jal_q       <= 1'b0;
            jalr_q      <= 1'b0;
            auipc_q     <= 1'b0;
            alu_op_q    <= 2'b00;
            wb_src_q    <= 2'b00;
            md_start_q  <= 1'b0;
            md_div_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            branch_q    <= branch_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            alu_src_q   <= alu_src_d;
            reg_write_q <= reg_write_d;
            jal_q       <= jal_d;
            jalr_q      <= jalr_d;
            auipc_q     <= auipc_d;
            alu_op_q    <= alu_op_d;
            wb_src_q    <= wb_src_d;
            md_start_q  <= md_start_d;
            md_div_q    <= md_div_d;
            illegal_q   <= illegal_d;
        end
    end

    // The registered bundle is all-zero while in MD, so completion terms OR in cleanly.
    assign ctrl_valid = valid_q | md_done;
    assign reg_write  = reg_write_q | md_done;
    assign wb_src     = wb_src_q | {md_done, md_done};
    assign branch     = branch_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign alu_src    = alu_src_q;
    assign jal        = jal_q;
    assign jalr       = jalr_q;
    assign auipc      = auipc_q;
    assign alu_op     = alu_op_q;
    assign md_start   = md_start_q;
    assign md_div     = md_div_q;
    assign illegal    = illegal_q;
    assign inst_ready = (state_q == S_IDLE);
    assign busy       = (state_q == S_MD);

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// tb/tb_ctrl_seq_unit.sv - directed self-checking bench for ctrl_seq_unit
module tb_ctrl_seq_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, inst_valid, funct7_0, flush;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       inst_ready, ctrl_valid, branch, mem_read, mem_write, alu_src, reg_write;
    logic       jal, jalr, auipc, md_start, md_div, busy, illegal;
    logic [1:0] alu_op, wb_src;

    logic       inst_valid1, funct7_01, flush1;
    logic [6:0] opcode1;
    logic [2:0] funct31;
    logic       inst_ready1, ctrl_valid1, branch1, mem_read1, mem_write1, alu_src1, reg_write1;
    logic       jal1, jalr1, auipc1, md_start1, md_div1, busy1, illegal1;
    logic [1:0] alu_op1, wb_src1;

    ctrl_seq_unit #(.MUL_LAT(4), .DIV_LAT(16), .CNT_W(6)) u_dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .opcode(opcode), .funct3(funct3), .funct7_0(funct7_0), .flush(flush),
        .ctrl_valid(ctrl_valid), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src(alu_src), .reg_write(reg_write), .jal(jal), .jalr(jalr), .auipc(auipc),
        .alu_op(alu_op), .wb_src(wb_src), .md_start(md_start), .md_div(md_div),
        .busy(busy), .illegal(illegal)
    );

    ctrl_seq_unit #(.MUL_LAT(1), .DIV_LAT(16), .CNT_W(6)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid1), .inst_ready(inst_ready1),
        .opcode(opcode1), .funct3(funct31), .funct7_0(funct7_01), .flush(flush1),
        .ctrl_valid(ctrl_valid1), .branch(branch1), .mem_read(mem_read1), .mem_write(mem_write1),
        .alu_src(alu_src1), .reg_write(reg_write1), .jal(jal1), .jalr(jalr1), .auipc(auipc1),
        .alu_op(alu_op1), .wb_src(wb_src1), .md_start(md_start1), .md_div(md_div1),
        .busy(busy1), .illegal(illegal1)
    );

    // {ctrl_valid, branch, mem_read, mem_write, alu_src, reg_write, jal, jalr, auipc, alu_op, wb_src}
    logic [12:0] bundle;
    assign bundle = {ctrl_valid, branch, mem_read, mem_write, alu_src, reg_write,
                     jal, jalr, auipc, alu_op, wb_src};

    localparam logic [12:0] B_NONE   = 13'b0000000000000;
    localparam logic [12:0] B_LOAD   = 13'b1010110000001;
    localparam logic [12:0] B_STORE  = 13'b1001100000000;
    localparam logic [12:0] B_BRANCH = 13'b1100000000100;
    localparam logic [12:0] B_JAL    = 13'b1000011000010;
    localparam logic [12:0] B_JALR   = 13'b1000110100010;
    localparam logic [12:0] B_AUIPC  = 13'b1000110010000;
    localparam logic [12:0] B_ADDI   = 13'b1000110001000;
    localparam logic [12:0] B_ADD    = 13'b1000010001000;
    localparam logic [12:0] B_MDONE  = 13'b1000010000011;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        inst_valid = 1'b1;
        opcode     = op;
        funct3     = f3;
        funct7_0   = f7;
    endtask

    initial begin
        rst_n = 1'b0; inst_valid = 1'b0; opcode = '0; funct3 = '0; funct7_0 = 1'b0; flush = 1'b0;
        inst_valid1 = 1'b0; opcode1 = '0; funct31 = '0; funct7_01 = 1'b0; flush1 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_bundle", 16'(bundle), 16'(B_NONE));
        check("rst_ready", 16'(inst_ready), 16'd1);
        check("rst_misc", 16'({busy, md_start, md_div, illegal}), 16'd0);

        // Stream of single-cycle ops, one per cycle.
        drive(7'b0000011, 3'b010, 1'b0); tick(); check("load", 16'(bundle), 16'(B_LOAD));
        drive(7'b0100011, 3'b010, 1'b0); tick(); check("store", 16'(bundle), 16'(B_STORE));
        drive(7'b1100011, 3'b000, 1'b0); tick(); check("branch", 16'(bundle), 16'(B_BRANCH));
        drive(7'b1101111, 3'b000, 1'b0); tick(); check("jal", 16'(bundle), 16'(B_JAL));
        drive(7'b1100111, 3'b000, 1'b0); tick(); check("jalr", 16'(bundle), 16'(B_JALR));
        drive(7'b0010111, 3'b000, 1'b0); tick(); check("auipc", 16'(bundle), 16'(B_AUIPC));
        drive(7'b0110011, 3'b000, 1'b0); tick(); check("add", 16'(bundle), 16'(B_ADD));
        inst_valid = 1'b0; tick();
        check("idle_bundle", 16'(bundle), 16'(B_NONE));

        // MUL, MUL_LAT=4: md_start T+1, busy T+1..T+4, ctrl_valid T+4, ready T+5.
        drive(7'b0110011, 3'b000, 1'b1); tick();
        check("mul_t1_start", 16'({md_start, md_div, busy, inst_ready, ctrl_valid}), 16'b10100);
        drive(7'b1111111, 3'b000, 1'b0); tick();
        check("mul_t2", 16'({md_start, busy, inst_ready, ctrl_valid, illegal}), 16'b01000);
        inst_valid = 1'b0; tick();
        check("mul_t3", 16'({busy, ctrl_valid}), 16'b10);
        tick();
        check("mul_t4_bundle", 16'(bundle), 16'(B_MDONE));
        check("mul_t4_busy", 16'({busy, inst_ready}), 16'b10);
        tick();
        check("mul_t5", 16'({busy, inst_ready, ctrl_valid}), 16'b010);

        // Flush at the second MD cycle.
        drive(7'b0110011, 3'b001, 1'b1); tick();
        inst_valid = 1'b0; tick();
        flush = 1'b1; #1;
        check("flush_md_cv", 16'(ctrl_valid), 16'd0);
        tick(); flush = 1'b0; #1;
        check("flush_md_after", 16'({busy, inst_ready, ctrl_valid}), 16'b010);
        drive(7'b0010011, 3'b000, 1'b0); tick();
        check("addi_after_flush", 16'(bundle), 16'(B_ADDI));
        inst_valid = 1'b0;

        // Flush coinciding with counter zero wins.
        drive(7'b0110011, 3'b000, 1'b1); tick();
        inst_valid = 1'b0; tick(); tick(); tick();
        flush = 1'b1; #1;
        check("flush_done_cv", 16'(ctrl_valid), 16'd0);
        tick(); flush = 1'b0; #1;
        check("flush_done_after", 16'({busy, inst_ready, ctrl_valid}), 16'b010);

        // Flush in IDLE suppresses the accepted op and illegal.
        drive(7'b0000011, 3'b010, 1'b0); flush = 1'b1; tick();
        check("flush_idle_load", 16'(bundle), 16'(B_NONE));
        drive(7'b1111111, 3'b000, 1'b0); tick();
        check("flush_idle_ill", 16'(illegal), 16'd0);
        flush = 1'b0;

        // Illegal opcode: one-cycle pulse.
        drive(7'b1111111, 3'b000, 1'b0); tick();
        check("illegal_pulse", 16'({illegal, ctrl_valid, inst_ready}), 16'b101);
        inst_valid = 1'b0; tick();
        check("illegal_clear", 16'(illegal), 16'd0);

        // DIV group.
        drive(7'b0110011, 3'b100, 1'b1); tick();
`ifdef CTRL_DIV_EN
        inst_valid = 1'b0;
        check("div_start", 16'({md_start, md_div, busy, illegal}), 16'b1110);
        begin
            int lat;
            lat = 1;
            while (!ctrl_valid && lat < 40) begin
                tick();
                lat++;
            end
            check("div_latency", 16'(lat), 16'd16);
            check("div_bundle", 16'(bundle), 16'(B_MDONE));
        end
        tick();
`else
        check("div_illegal", 16'({illegal, md_start, md_div, busy, ctrl_valid}), 16'b10000);
        inst_valid = 1'b0; tick();
`endif

        // Reset asserted while in MD.
        drive(7'b0110011, 3'b000, 1'b1); tick();
        inst_valid = 1'b0; rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("rst_md", 16'({busy, inst_ready, ctrl_valid}), 16'b010);
        tick(); tick(); tick();
        check("rst_md_no_cv", 16'(ctrl_valid), 16'd0);

        // MUL_LAT=1 instance: start and completion in the same cycle.
        inst_valid1 = 1'b1; opcode1 = 7'b0110011; funct31 = 3'b000; funct7_01 = 1'b1;
        tick();
        inst_valid1 = 1'b0;
        check("lat1_same", 16'({md_start1, ctrl_valid1, busy1, reg_write1, wb_src1}), 16'b111111);
        tick();
        check("lat1_after", 16'({busy1, inst_ready1, ctrl_valid1}), 16'b010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
